// File: rtl/cache_miss_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : cache_miss_controller_if
//  Description : Bus bundle between the cache miss controller and its CPU,
//                cache array and main-memory neighbours. The master modport
//                is the controller side; slave is the environment side.
//  Revision    : 1.0  initial release
// ============================================================================
interface cache_miss_controller_if #(
    parameter int ADDR_W = 15,
    parameter int OFF_W  = 2,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    // CPU read port
    logic                         cpu_req;
    logic [ADDR_W-1:0]            cpu_addr;
    logic                         cpu_ack;
    logic [DATA_W-1:0]            cpu_data;
    logic                         busy;
    // Cache array port
    logic [ADDR_W-1:0]            cache_addr;
    logic                         cache_hit;
    logic [DATA_W-1:0]            cache_data;
    logic                         cache_fill;
    logic [(DATA_W<<OFF_W)-1:0]   cache_line;
    // Main-memory burst port
    logic                         mem_req;
    logic [ADDR_W-1:0]            mem_addr;
    logic                         mem_ack;
    logic [DATA_W-1:0]            mem_rdata;
    // Performance counters
    logic                         stat_clr;
    logic [CNT_W-1:0]             hit_cnt;
    logic [CNT_W-1:0]             miss_cnt;

    modport master (
        input  cpu_req, cpu_addr, cache_hit, cache_data, mem_ack, mem_rdata, stat_clr,
        output cpu_ack, cpu_data, busy, cache_addr, cache_fill, cache_line,
               mem_req, mem_addr, hit_cnt, miss_cnt
    );

    modport slave (
        output cpu_req, cpu_addr, cache_hit, cache_data, mem_ack, mem_rdata, stat_clr,
        input  cpu_ack, cpu_data, busy, cache_addr, cache_fill, cache_line,
               mem_req, mem_addr, hit_cnt, miss_cnt
    );
endinterface
`default_nettype wire

// File: rtl/cache_miss_controller.sv
`default_nettype none
// ============================================================================
//  Module      : cache_miss_controller
//  Description : Read-miss sequencer for a direct-mapped cache. Looks up the
//                latched CPU address, returns hits directly, and on a miss
//                bursts the whole line from memory (word 0 first), writes it
//                into the cache in one fill cycle and re-looks-up. Keeps
//                saturating hit/miss counters.
//  Revision    : 1.0  initial release
// ============================================================================
module cache_miss_controller #(
    parameter int ADDR_W = 15,
    parameter int OFF_W  = 2,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cache_miss_controller_if.master bus
);

    localparam int                c_line_w    = DATA_W << OFF_W;
    localparam logic [OFF_W-1:0]  c_last_beat = '1;
    localparam logic [CNT_W-1:0]  c_cnt_max   = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_FETCH  = 2'd2,
        ST_FILL   = 2'd3
    } state_t;

    state_t                 state_q,    state_d;
    logic [ADDR_W-1:0]      addr_q,     addr_d;
    logic [OFF_W-1:0]       beat_q,     beat_d;
    logic [c_line_w-1:0]    line_q,     line_d;
    logic                   refill_q,   refill_d;
    logic [CNT_W-1:0]       hit_cnt_q,  hit_cnt_d;
    logic [CNT_W-1:0]       miss_cnt_q, miss_cnt_d;

    logic                   w_hit_inc;
    logic                   w_miss_inc;
    logic                   w_ack;

    // State and datapath registers; reset abandons any burst in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            beat_q     <= '0;
            line_q     <= '0;
            refill_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            beat_q     <= beat_d;
            line_q     <= line_d;
            refill_q   <= refill_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Next-state logic: capture, lookup, burst assembly and fill sequencing
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        beat_d     = beat_q;
        line_d     = line_q;
        refill_d   = refill_q;
        w_hit_inc  = 1'b0;
        w_miss_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_req) begin
                    addr_d  = bus.cpu_addr;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                // The refill flag only qualifies this one lookup
                refill_d = 1'b0;
                if (bus.cache_hit) begin
                    w_hit_inc = ~refill_q;
                    state_d   = ST_IDLE;
                end else begin
                    w_miss_inc = 1'b1;
                    beat_d     = '0;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bus.mem_ack) begin
                    line_d[beat_q*DATA_W +: DATA_W] = bus.mem_rdata;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == c_last_beat) begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                refill_d = 1'b1;
                state_d  = ST_LOOKUP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Saturating performance counters; a clear wins over a same-cycle increment
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (bus.stat_clr) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else begin
            if (w_hit_inc && (hit_cnt_q != c_cnt_max)) begin
                hit_cnt_d = hit_cnt_q + 1'b1;
            end
            if (w_miss_inc && (miss_cnt_q != c_cnt_max)) begin
                miss_cnt_d = miss_cnt_q + 1'b1;
            end
        end
    end

    // Output decode; every output has a defined value in every state
    always_comb begin
        w_ack          = (state_q == ST_LOOKUP) && bus.cache_hit;
        bus.cpu_ack    = w_ack;
        bus.cpu_data   = w_ack ? bus.cache_data : '0;
        bus.busy       = (state_q != ST_IDLE);
        bus.cache_addr = addr_q;
        bus.cache_fill = (state_q == ST_FILL);
        bus.cache_line = line_q;
        bus.mem_req    = (state_q == ST_FETCH);
        bus.mem_addr   = (state_q == ST_FETCH) ? {addr_q[ADDR_W-1:OFF_W], beat_q} : '0;
        bus.hit_cnt    = hit_cnt_q;
        bus.miss_cnt   = miss_cnt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_miss_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_miss_controller
//  Description : Self-checking bench for cache_miss_controller. Provides a
//                behavioural cache array and memory, and compares the DUT
//                against a transaction-level reference model (tag table,
//                latency formula, saturating counters).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cache_miss_controller;

    localparam int ADDR_W = 15;
    localparam int OFF_W  = 2;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;      // narrow counters so saturation is reachable
    localparam int LINE_W = DATA_W << OFF_W;
    localparam int IDX_W  = 10;
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    cache_miss_controller_if #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    cache_miss_controller #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory contents: a unique word per address
    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a[7:0], 2'b10, a, 7'h35};
    endfunction

    function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < 4; k++) begin
            l[k*DATA_W +: DATA_W] = mem_word({a[ADDR_W-1:OFF_W], 2'(k)});
        end
        return l;
    endfunction

    // Behavioural cache array (environment) and memory data path
    bit                 env_valid [1 << IDX_W];
    bit [TAG_W-1:0]     env_tag   [1 << IDX_W];
    bit [LINE_W-1:0]    env_line  [1 << IDX_W];

    wire [IDX_W-1:0] c_idx = bus.cache_addr[OFF_W +: IDX_W];
    wire [TAG_W-1:0] c_tag = bus.cache_addr[ADDR_W-1 -: TAG_W];
    wire [OFF_W-1:0] c_off = bus.cache_addr[OFF_W-1:0];

    assign bus.cache_hit  = env_valid[c_idx] && (env_tag[c_idx] == c_tag);
    assign bus.cache_data = env_line[c_idx][c_off*DATA_W +: DATA_W];
    assign bus.mem_rdata  = mem_word(bus.mem_addr);

    always @(posedge clk) begin
        if (bus.cache_fill) begin
            env_valid[c_idx] <= 1'b1;
            env_tag[c_idx]   <= c_tag;
            env_line[c_idx]  <= bus.cache_line;
        end
    end

    // Reference model state
    bit             ref_valid [1 << IDX_W];
    int             ref_tag   [1 << IDX_W];
    int             exp_hit_cnt  = 0;
    int             exp_miss_cnt = 0;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    // One CPU read through the DUT, fully checked against the model.
    // stall_max/stall_rand: memory wait cycles inserted before each beat.
    task automatic do_read(input logic [ADDR_W-1:0] addr, input int stall_max,
                           input bit stall_rand, input bit clr_at_ack, input bit keep_req);
        int idx, tag, exp_lat, exp_fetch, total_stall;
        int stalls [4];
        int cyc, beat, stall_left, fetch_cyc, fills, lat;
        bit hit_now, got, bad_idle;
        logic [ADDR_W-1:0] exp_ma;
        idx = int'(addr[OFF_W +: IDX_W]);
        tag = int'(addr[ADDR_W-1 -: TAG_W]);
        hit_now = ref_valid[idx] && (ref_tag[idx] == tag);
        total_stall = 0;
        for (int k = 0; k < 4; k++) begin
            stalls[k] = stall_rand ? int'($urandom_range(0, stall_max)) : stall_max;
            total_stall += stalls[k];
        end
        exp_fetch = hit_now ? 0 : 4 + total_stall;
        exp_lat   = hit_now ? 1 : 3 + exp_fetch;

        bus.cpu_req  = 1'b1;
        bus.cpu_addr = addr;
        @(posedge clk);
        cyc = 1; beat = 0; stall_left = stalls[0]; fetch_cyc = 0; fills = 0;
        lat = 0; got = 1'b0; bad_idle = 1'b0;
        while (!got && cyc <= 100) begin
            @(negedge clk);
            if (cyc == 1) begin
                if (!keep_req) bus.cpu_addr = ~addr;   // must be ignored now
                chk_cnt++;
                if (bus.cache_addr !== addr)
                    $display("FAIL cache_addr: got %h want %h", bus.cache_addr, addr);
                else pass_cnt++;
            end
            if (bus.mem_req) begin
                fetch_cyc++;
                if (stall_left > 0) begin
                    bus.mem_ack = 1'b0;
                    stall_left--;
                end else begin
                    exp_ma = {addr[ADDR_W-1:OFF_W], 2'(beat)};
                    chk_cnt++;
                    if (bus.mem_addr !== exp_ma)
                        $display("FAIL mem_addr beat %0d: got %h want %h", beat, bus.mem_addr, exp_ma);
                    else pass_cnt++;
                    bus.mem_ack = 1'b1;
                    beat++;
                    stall_left = (beat < 4) ? stalls[beat] : 0;
                end
            end else begin
                bus.mem_ack = 1'b0;
                if (bus.mem_addr !== '0) bad_idle = 1'b1;
            end
            if (bus.cache_fill) begin
                fills++;
                chk_cnt++;
                if (bus.cache_line !== line_of(addr))
                    $display("FAIL cache_line: got %h want %h", bus.cache_line, line_of(addr));
                else pass_cnt++;
            end
            if (bus.cpu_ack) begin
                got = 1'b1;
                lat = cyc;
                chk_cnt++;
                if (bus.cpu_data !== mem_word(addr))
                    $display("FAIL cpu_data @%h: got %h want %h", addr, bus.cpu_data, mem_word(addr));
                else pass_cnt++;
                bus.stat_clr = clr_at_ack;
                if (!keep_req) bus.cpu_req = 1'b0;
            end else begin
                if (bus.cpu_data !== '0) bad_idle = 1'b1;
                cyc++;
            end
        end
        bus.mem_ack = 1'b0;
        chk_cnt++;
        if (!got) $display("FAIL ack_timeout @%h: got no ack want ack within 100 cycles", addr);
        else pass_cnt++;

        // Model update
        if (hit_now) begin
            exp_hit_cnt = sat_inc(exp_hit_cnt);
        end else begin
            exp_miss_cnt   = sat_inc(exp_miss_cnt);
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tag;
        end
        if (clr_at_ack) begin
            exp_hit_cnt  = 0;
            exp_miss_cnt = 0;
        end

        @(negedge clk);
        bus.stat_clr = 1'b0;
        chk_cnt++;
        if (lat !== exp_lat) $display("FAIL latency @%h: got %0d want %0d", addr, lat, exp_lat);
        else pass_cnt++;
        chk_cnt++;
        if (fetch_cyc !== exp_fetch) $display("FAIL fetch_cycles @%h: got %0d want %0d", addr, fetch_cyc, exp_fetch);
        else pass_cnt++;
        chk_cnt++;
        if (fills !== (hit_now ? 0 : 1)) $display("FAIL fill_count @%h: got %0d want %0d", addr, fills, hit_now ? 0 : 1);
        else pass_cnt++;
        chk_cnt++;
        if (bad_idle) $display("FAIL idle_outputs @%h: got nonzero cpu_data/mem_addr want 0", addr);
        else pass_cnt++;
        chk_cnt++;
        if (int'(bus.hit_cnt) !== exp_hit_cnt) $display("FAIL hit_cnt: got %0d want %0d", bus.hit_cnt, exp_hit_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (int'(bus.miss_cnt) !== exp_miss_cnt) $display("FAIL miss_cnt: got %0d want %0d", bus.miss_cnt, exp_miss_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL busy_after: got %b want 0", bus.busy);
        else pass_cnt++;
    endtask

    task automatic check_all_zero(input string tag_s);
        chk_cnt++;
        if ({bus.cpu_ack, bus.busy, bus.cache_fill, bus.mem_req} !== 4'b0 ||
            bus.cpu_data !== '0 || bus.cache_addr !== '0 || bus.mem_addr !== '0 ||
            bus.cache_line !== '0 || bus.hit_cnt !== '0 || bus.miss_cnt !== '0)
            $display("FAIL %s: got ack=%b busy=%b fill=%b mreq=%b maddr=%h caddr=%h hit=%0d miss=%0d want all 0",
                     tag_s, bus.cpu_ack, bus.busy, bus.cache_fill, bus.mem_req, bus.mem_addr,
                     bus.cache_addr, bus.hit_cnt, bus.miss_cnt);
        else pass_cnt++;
    endtask

    task automatic clear_stats();
        @(negedge clk);
        bus.stat_clr = 1'b1;
        @(negedge clk);
        bus.stat_clr = 1'b0;
        exp_hit_cnt  = 0;
        exp_miss_cnt = 0;
        chk_cnt++;
        if (bus.hit_cnt !== '0 || bus.miss_cnt !== '0)
            $display("FAIL stat_clr: got hit=%0d miss=%0d want 0/0", bus.hit_cnt, bus.miss_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.mem_ack = 1'b0; bus.stat_clr = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_miss_fill();
        do_read(15'h1234, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_hit();
        do_read(15'h1236, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stalls();
        do_read(15'h2468, 3, 1'b0, 1'b0, 1'b0);
        do_read(15'h246B, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_fetch();
        int acked, guard;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 15'h3ABD;
        @(posedge clk);
        acked = 0; guard = 0;
        while (guard < 50) begin
            @(negedge clk);
            guard++;
            if (bus.mem_req && acked == 2) break;
            bus.mem_ack = bus.mem_req;
            if (bus.mem_req) acked++;
        end
        chk_cnt++;
        if (guard >= 50) $display("FAIL reach_beat2: got no beat 2 want beat 2 within 50 cycles");
        else pass_cnt++;
        bus.mem_ack = 1'b0;
        bus.cpu_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_mid_fetch");
        exp_hit_cnt  = 0;
        exp_miss_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle_after_mid_reset");
        do_read(15'h3ABD, 1, 1'b1, 1'b0, 1'b0);   // line never filled: refetch from beat 0
    endtask

    task automatic test_conflict();
        clear_stats();
        do_read(15'h0004, 0, 1'b0, 1'b0, 1'b0);
        do_read(15'h1004, 0, 1'b0, 1'b0, 1'b0);
        chk_cnt++;
        if (bus.miss_cnt !== 4'd2) $display("FAIL conflict_miss_cnt: got %0d want 2", bus.miss_cnt);
        else pass_cnt++;
        do_read(15'h0005, 0, 1'b0, 1'b0, 1'b0);  // evicted by 0x1004: misses again
    endtask

    task automatic test_saturation();
        logic [ADDR_W-1:0] a;
        clear_stats();
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            a = {3'd5, 10'(10'h100 + i), 2'(i)};
            do_read(a, 0, 1'b0, 1'b0, 1'b0);
        end
        chk_cnt++;
        if (int'(bus.miss_cnt) !== CNT_MAX) $display("FAIL miss_saturate: got %0d want %0d", bus.miss_cnt, CNT_MAX);
        else pass_cnt++;
        // Hit with a same-cycle clear: clear wins
        do_read(a, 0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_read(15'h0A10, 0, 1'b0, 1'b0, 1'b1);   // req left high after ack
        do_read(15'h0A10, 0, 1'b0, 1'b0, 1'b0);   // immediately recaptured: hit
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL no_spurious_start: got busy=%b want 0", bus.busy);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] a;
        int idxs [4];
        idxs[0] = 5; idxs[1] = 6; idxs[2] = 12'h48D & 10'h3FF; idxs[3] = 9;
        for (int n = 0; n < 40; n++) begin
            a = {3'($urandom_range(0, 1)), 10'(idxs[$urandom_range(0, 3)]), 2'($urandom_range(0, 3))};
            do_read(a, 2, 1'b1, ($urandom_range(0, 9) == 0), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_miss_fill();
        test_hit();
        test_stalls();
        test_reset_mid_fetch();
        test_conflict();
        test_saturation();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
